// File: rtl/dmem_access_ctrl_pkg.sv
// dmem_access_ctrl_pkg: op codes, FSM states and default memory map for the DMEM sequencer
package dmem_access_ctrl_pkg;
  typedef enum logic [2:0] {
    OP_LW  = 3'd0,
    OP_LH  = 3'd1,
    OP_LHU = 3'd2,
    OP_LB  = 3'd3,
    OP_LBU = 3'd4,
    OP_SW  = 3'd5,
    OP_SH  = 3'd6,
    OP_SB  = 3'd7
  } op_e;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2,
    ST_ERR    = 2'd3
  } state_e;
  localparam logic [31:0] DMEM_BASE_DEF  = 32'h1001_0000;
  localparam int          DMEM_BYTES_DEF = 4096;
  function automatic logic is_store(input op_e op);
    return op inside {OP_SW, OP_SH, OP_SB};
  endfunction
endpackage

// File: rtl/dmem_access_ctrl_req_check.sv
// dmem_access_ctrl_req_check: combinational range and alignment check of a CPU data address
module dmem_access_ctrl_req_check
  import dmem_access_ctrl_pkg::*;
#(
  parameter logic [31:0] DMEM_BASE  = DMEM_BASE_DEF,
  parameter int          DMEM_BYTES = DMEM_BYTES_DEF
) (
  input  op_e         i_op,
  input  logic [31:0] i_addr,
  output logic [11:0] o_offset,
  output logic        o_misaligned,
  output logic        o_out_of_range
);
  logic [31:0] w_off;
  // wrapping subtract: addresses below the base become huge offsets and fail the range test
  assign w_off          = i_addr - DMEM_BASE;
  assign o_offset       = w_off[11:0];
  assign o_out_of_range = w_off >= 32'(DMEM_BYTES);
  assign o_misaligned   = ((i_op == OP_LW || i_op == OP_SW) && i_addr[1:0] != 2'b00) ||
                          ((i_op == OP_LH || i_op == OP_LHU || i_op == OP_SH) && i_addr[0]);
endmodule

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: one-at-a-time load/store sequencer between the CPU pipeline and synchronous DMEM
module dmem_access_ctrl
  import dmem_access_ctrl_pkg::*;
#(
  parameter logic [31:0] DMEM_BASE  = DMEM_BASE_DEF,
  parameter int          DMEM_BYTES = DMEM_BYTES_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] bad_addr,
  output logic        busy,
  output logic        dm_ena,
  output logic        dm_wena,
  output logic        dm_rena,
  output logic        dm_lw,
  output logic        dm_lh,
  output logic        dm_lhu,
  output logic        dm_lb,
  output logic        dm_lbu,
  output logic        dm_sw,
  output logic        dm_sh,
  output logic        dm_sb,
  output logic [11:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata
);
  state_e      r_state, w_next;
  op_e         r_op;
  logic [11:0] r_dm_addr;
  logic [31:0] r_dm_wdata, r_bad_addr;
  logic [11:0] w_offset;
  logic        w_misaligned, w_out_of_range, w_bad, w_accept, w_access, w_store, w_resp;

  dmem_access_ctrl_req_check #(
    .DMEM_BASE (DMEM_BASE),
    .DMEM_BYTES(DMEM_BYTES)
  ) u_check (
    .i_op          (op_e'(req_op)),
    .i_addr        (req_addr),
    .o_offset      (w_offset),
    .o_misaligned  (w_misaligned),
    .o_out_of_range(w_out_of_range)
  );

  assign w_bad    = w_misaligned | w_out_of_range;
  assign w_accept = (r_state == ST_IDLE) & req_valid;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else r_state <= w_next;
  end

  // next state: failed checks skip the memory entirely
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   w_next = req_valid ? (w_bad ? ST_ERR : ST_ACCESS) : ST_IDLE;
      ST_ACCESS: w_next = ST_RESP;
      default:   w_next = ST_IDLE;
    endcase
  end

  // latch a good request; dm_addr/dm_wdata keep their value between accesses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op       <= OP_LW;
      r_dm_addr  <= '0;
      r_dm_wdata <= '0;
    end else if (w_accept && !w_bad) begin
      r_op       <= op_e'(req_op);
      r_dm_addr  <= w_offset;
      r_dm_wdata <= req_wdata;
    end
  end

  // remember the address of the most recent rejected request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_bad_addr <= '0;
    else if (w_accept && w_bad) r_bad_addr <= req_addr;
  end

  // output decode: DMEM controls only in ACCESS, response in RESP/ERR
  always_comb begin
    w_access   = r_state == ST_ACCESS;
    w_resp     = r_state == ST_RESP;
    w_store    = is_store(r_op);
    req_ready  = rst_n & (r_state == ST_IDLE);
    busy       = r_state != ST_IDLE;
    dm_ena     = w_access;
    dm_wena    = w_access & w_store;
    dm_rena    = w_access & ~w_store;
    dm_lw      = w_access & (r_op == OP_LW);
    dm_lh      = w_access & (r_op == OP_LH);
    dm_lhu     = w_access & (r_op == OP_LHU);
    dm_lb      = w_access & (r_op == OP_LB);
    dm_lbu     = w_access & (r_op == OP_LBU);
    dm_sw      = w_access & (r_op == OP_SW);
    dm_sh      = w_access & (r_op == OP_SH);
    dm_sb      = w_access & (r_op == OP_SB);
    resp_valid = w_resp | (r_state == ST_ERR);
    resp_err   = r_state == ST_ERR;
    resp_rdata = (w_resp && !w_store) ? dm_rdata : '0;
  end

  assign dm_addr  = r_dm_addr;
  assign dm_wdata = r_dm_wdata;
  assign bad_addr = r_bad_addr;
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: directed table, hand sequences and random traffic against a request-level model
module tb_dmem_access_ctrl;
  localparam logic [31:0] BASE = 32'h1001_0000;

  logic        clk, rst_n, req_valid, req_ready, resp_valid, resp_err, busy;
  logic [2:0]  req_op;
  logic [31:0] req_addr, req_wdata, resp_rdata, bad_addr, dm_wdata, dm_rdata;
  logic        dm_ena, dm_wena, dm_rena, dm_lw, dm_lh, dm_lhu, dm_lb, dm_lbu, dm_sw, dm_sh, dm_sb;
  logic [11:0] dm_addr;
  logic [7:0]  flags;

  int checks = 0, errors = 0, resp_cnt = 0;
  logic [31:0] exp_bad = 0;
  logic [7:0]  dmem    [4096];
  logic [7:0]  ref_mem [4096];

  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
  } vec_t;
  vec_t tbl[$];

  dmem_access_ctrl dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .bad_addr(bad_addr), .busy(busy), .dm_ena(dm_ena), .dm_wena(dm_wena),
    .dm_rena(dm_rena), .dm_lw(dm_lw), .dm_lh(dm_lh), .dm_lhu(dm_lhu), .dm_lb(dm_lb), .dm_lbu(dm_lbu),
    .dm_sw(dm_sw), .dm_sh(dm_sh), .dm_sb(dm_sb), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  assign flags = {dm_lw, dm_lh, dm_lhu, dm_lb, dm_lbu, dm_sw, dm_sh, dm_sb};

  // little-endian synchronous DMEM; loads are extended by the memory
  always @(posedge clk) begin
    if (dm_ena && dm_wena) begin
      if (dm_sb) dmem[dm_addr] <= dm_wdata[7:0];
      if (dm_sh) begin
        dmem[dm_addr] <= dm_wdata[7:0];
        dmem[dm_addr + 12'd1] <= dm_wdata[15:8];
      end
      if (dm_sw) begin
        dmem[dm_addr] <= dm_wdata[7:0];
        dmem[dm_addr + 12'd1] <= dm_wdata[15:8];
        dmem[dm_addr + 12'd2] <= dm_wdata[23:16];
        dmem[dm_addr + 12'd3] <= dm_wdata[31:24];
      end
    end
    if (dm_ena && dm_rena) begin
      if (dm_lw) dm_rdata <= {dmem[dm_addr + 12'd3], dmem[dm_addr + 12'd2], dmem[dm_addr + 12'd1], dmem[dm_addr]};
      if (dm_lh) dm_rdata <= {{16{dmem[dm_addr + 12'd1][7]}}, dmem[dm_addr + 12'd1], dmem[dm_addr]};
      if (dm_lhu) dm_rdata <= {16'h0, dmem[dm_addr + 12'd1], dmem[dm_addr]};
      if (dm_lb) dm_rdata <= {{24{dmem[dm_addr][7]}}, dmem[dm_addr]};
      if (dm_lbu) dm_rdata <= {24'h0, dmem[dm_addr]};
    end
  end

  always @(posedge clk) if (resp_valid) resp_cnt <= resp_cnt + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // request-level reference: range/alignment rule and byte-array memory
  function automatic void model(input logic [2:0] op, input logic [31:0] addr,
                                output logic err, output logic [31:0] rd);
    logic [31:0] off;
    logic [11:0] o;
    logic [15:0] h;
    int sz;
    off = addr - BASE;
    o = off[11:0];
    sz = (op == 0 || op == 5) ? 4 : (op == 1 || op == 2 || op == 6) ? 2 : 1;
    err = (off >= 32'd4096) || (addr % sz != 0);
    h = {ref_mem[o + 12'd1], ref_mem[o]};
    case (op)
      3'd0: rd = {ref_mem[o + 12'd3], ref_mem[o + 12'd2], h};
      3'd1: rd = {{16{h[15]}}, h};
      3'd2: rd = {16'h0, h};
      3'd3: rd = {{24{h[7]}}, h[7:0]};
      3'd4: rd = {24'h0, h[7:0]};
      default: rd = 0;
    endcase
    if (err) rd = 0;
  endfunction

  function automatic void model_store(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] w);
    logic [31:0] off;
    off = addr - BASE;
    for (int i = 0; i < (op == 5 ? 4 : op == 6 ? 2 : 1); i++) ref_mem[off[11:0] + 12'(i)] = w[8*i +: 8];
  endfunction

  task automatic xact(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic exp_err, input logic [31:0] exp_rd);
    int n = 0, lat = 0, ena_n = 0;
    logic got_err = 0;
    logic [31:0] got_rd = 0, off;
    off = addr - BASE;
    @(negedge clk);
    req_op = op; req_addr = addr; req_wdata = wdata; req_valid = 1;
    while (!req_ready && n < 10) begin @(negedge clk); n++; end
    if (!req_ready) begin
      chk("ready_timeout", 0, 1);
      req_valid = 0;
      return;
    end
    @(negedge clk);
    req_valid = 0;
    for (int k = 1; k <= 4; k++) begin
      if (dm_ena) begin
        ena_n++;
        chk("flags", flags, 8'h80 >> op);
        chk("dm_wena", dm_wena, op >= 5);
        chk("dm_rena", dm_rena, op < 5);
        chk("dm_addr", dm_addr, off[11:0]);
        if (op >= 5) chk("dm_wdata", dm_wdata, wdata);
      end
      if (resp_valid) begin
        lat = k; got_err = resp_err; got_rd = resp_rdata;
        chk("busy_resp", busy, 1);
        break;
      end
      @(negedge clk);
    end
    if (exp_err) exp_bad = addr;
    chk("latency", lat, exp_err ? 1 : 2);
    chk("resp_err", got_err, exp_err);
    chk("resp_rdata", got_rd, exp_rd);
    chk("dm_ena_pulses", ena_n, exp_err ? 0 : 1);
    chk("bad_addr", bad_addr, exp_bad);
    if (!exp_err && op >= 5) model_store(op, addr, wdata);
  endtask

  initial begin
    logic e;
    logic [31:0] r, a, c0;
    for (int i = 0; i < 4096; i++) begin dmem[i] = 0; ref_mem[i] = 0; end
    dm_rdata = 0; req_valid = 0; req_op = 0; req_addr = 0; req_wdata = 0;
    rst_n = 0;
    #1;
    chk("reset_outputs", {req_ready, resp_valid, resp_err, busy, dm_ena, flags, bad_addr, dm_addr, dm_wdata}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("ready_after_reset", {req_ready, busy, resp_valid}, 3'b100);

    tbl.push_back('{3'd5, 32'h1001_0004, 32'hDEAD_BEEF, 1'b0, 32'h0});
    tbl.push_back('{3'd0, 32'h1001_0004, 32'h0, 1'b0, 32'hDEAD_BEEF});
    tbl.push_back('{3'd4, 32'h1001_0004, 32'h0, 1'b0, 32'h0000_00EF});
    tbl.push_back('{3'd7, 32'h1001_0007, 32'h0000_0080, 1'b0, 32'h0});
    tbl.push_back('{3'd3, 32'h1001_0007, 32'h0, 1'b0, 32'hFFFF_FF80});
    tbl.push_back('{3'd4, 32'h1001_0007, 32'h0, 1'b0, 32'h0000_0080});
    tbl.push_back('{3'd0, 32'h1001_0004, 32'h0, 1'b0, 32'h80AD_BEEF});
    tbl.push_back('{3'd1, 32'h1001_0003, 32'h0, 1'b1, 32'h0});
    tbl.push_back('{3'd0, 32'h1001_1000, 32'h0, 1'b1, 32'h0});
    tbl.push_back('{3'd0, 32'h1000_FFFC, 32'h0, 1'b1, 32'h0});
    tbl.push_back('{3'd6, 32'h1001_0FFE, 32'h0000_F234, 1'b0, 32'h0});
    tbl.push_back('{3'd1, 32'h1001_0FFE, 32'h0, 1'b0, 32'hFFFF_F234});
    tbl.push_back('{3'd2, 32'h1001_0FFE, 32'h0, 1'b0, 32'h0000_F234});
    tbl.push_back('{3'd3, 32'h1001_0FFF, 32'h0, 1'b0, 32'hFFFF_FFF2});
    tbl.push_back('{3'd0, 32'h1001_0FFF, 32'h0, 1'b1, 32'h0});
    tbl.push_back('{3'd5, 32'h1001_0002, 32'h1111_1111, 1'b1, 32'h0});
    tbl.push_back('{3'd6, 32'h1001_0001, 32'h2222_2222, 1'b1, 32'h0});
    tbl.push_back('{3'd7, 32'h1000_FFFF, 32'h3333_3333, 1'b1, 32'h0});
    tbl.push_back('{3'd4, 32'h1001_0000, 32'h0, 1'b0, 32'h0});
    foreach (tbl[i]) xact(tbl[i].op, tbl[i].addr, tbl[i].wdata, tbl[i].err, tbl[i].rdata);

    // request held through ACCESS/RESP with a different op behind it
    @(negedge clk);
    c0 = resp_cnt;
    req_op = 0; req_addr = 32'h1001_0004; req_wdata = 0; req_valid = 1;
    chk("hold_ready_idle", req_ready, 1);
    @(negedge clk);
    req_op = 5; req_addr = 32'h1001_0010; req_wdata = 32'h1234_5678;
    chk("hold_access", {busy, req_ready, flags}, {2'b10, 8'h80});
    @(negedge clk);
    chk("hold_resp", {busy, req_ready, resp_valid}, 3'b101);
    chk("hold_rdata", resp_rdata, 32'h80AD_BEEF);
    @(negedge clk);
    chk("hold_idle", {req_ready, resp_valid}, 2'b10);
    @(negedge clk);
    chk("hold_second", {flags, dm_addr, dm_wdata}, {8'h04, 12'h010, 32'h1234_5678});
    req_valid = 0;
    @(negedge clk);
    chk("hold_second_resp", {resp_valid, resp_err, resp_rdata}, {2'b10, 32'h0});
    repeat (3) @(negedge clk);
    chk("hold_resp_count", resp_cnt - c0, 2);
    model_store(5, 32'h1001_0010, 32'h1234_5678);

    for (int i = 0; i < 300; i++) begin
      logic [2:0] op;
      int sel;
      op = 3'($urandom_range(0, 7));
      sel = $urandom_range(0, 9);
      a = BASE + $urandom_range(0, 4095);
      if (sel < 6) a = (op == 0 || op == 5) ? {a[31:2], 2'b00} : (op == 1 || op == 2 || op == 6) ? {a[31:1], 1'b0} : a;
      if (sel == 8) a = BASE + 32'd4096 + $urandom_range(0, 15);
      if (sel == 9) a = $urandom;
      model(op, a, e, r);
      xact(op, a, $urandom, e, r);
    end

    // reset while a store is in ACCESS
    @(negedge clk);
    req_op = 5; req_addr = 32'h1001_0020; req_wdata = 32'hAAAA_5555; req_valid = 1;
    @(negedge clk);
    chk("rst_in_access", dm_ena, 1);
    req_valid = 0;
    c0 = resp_cnt;
    #1 rst_n = 0;
    #1;
    chk("rst_outputs", {req_ready, resp_valid, resp_err, busy, dm_ena, dm_wena, dm_rena, flags,
                        resp_rdata, bad_addr, dm_addr, dm_wdata}, 0);
    exp_bad = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("rst_no_resp", resp_cnt - c0, 0);
    xact(5, 32'h1001_0024, 32'hCAFE_F00D, 0, 0);
    xact(0, 32'h1001_0024, 0, 0, 32'hCAFE_F00D);
    model(0, 32'h1001_0010, e, r);
    xact(0, 32'h1001_0010, 0, e, r);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
